// File: rtl/calc_entry.sv
// ============================================================================
// Module   : calc_entry
// Purpose  : Keypad calculator front end. Builds decimal operands from key
//            codes, performs chained add/subtract and drives a
//            signed-magnitude value to the display driver.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module calc_entry #(
  parameter int MAX_DIGITS = 4,
  parameter int WIDTH      = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_code,
  input  logic             key_valid,
  output logic [WIDTH-1:0] disp_mag,
  output logic             disp_neg,
  output logic [1:0]       op_pending,
  output logic             result_valid,
  output logic             err
);

  localparam int SW = WIDTH + 2;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  // Largest magnitude the display may show, as a signed SW-bit constant
  localparam logic signed [SW-1:0] LIMIT_S = SW'(10**MAX_DIGITS - 1);

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_CLR = 4'd12;
  localparam logic [3:0] KEY_BSP = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  typedef enum logic [2:0] {
    S_ENTRY_A = 3'd0,
    S_OP_WAIT = 3'd1,
    S_ENTRY_B = 3'd2,
    S_RESULT  = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic [CW-1:0]          count_q, count_d;
  logic signed [SW-1:0]   opa_q, opa_d;
  logic [1:0]             op_q, op_d;
  logic                   kv_q;
  logic                   rv_d;

  logic [WIDTH-1:0]       disp_mag_d;
  logic                   disp_neg_d;
  logic [1:0]             op_pending_d;
  logic                   err_d;

  logic                   w_accept;
  logic                   w_is_digit;
  logic                   w_is_op;
  logic [1:0]             w_key_op;
  logic [WIDTH-1:0]       w_digit;
  logic signed [SW-1:0]   w_acc_s;
  logic signed [SW-1:0]   w_res;
  logic signed [SW-1:0]   w_res_abs;
  logic                   w_ovf;

  // Key decode and arithmetic helpers for the current key / operands
  assign w_accept   = key_valid & ~kv_q;
  assign w_is_digit = (key_code <= 4'd9);
  assign w_is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);
  assign w_key_op   = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
  assign w_digit    = {{(WIDTH-4){1'b0}}, key_code};
  assign w_acc_s    = signed'({2'b00, acc_q});
  assign w_res      = (op_q == OP_SUB) ? (opa_q - w_acc_s) : (opa_q + w_acc_s);
  assign w_res_abs  = w_res[SW-1] ? -w_res : w_res;
  assign w_ovf      = (w_res_abs > LIMIT_S);

  // Next-state logic: at most one accepted key acts per clock
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    opa_d   = opa_q;
    op_d    = op_q;
    rv_d    = 1'b0;

    if (w_accept) begin
      if (key_code == KEY_CLR) begin
        state_d = S_ENTRY_A;
        acc_d   = '0;
        count_d = '0;
        opa_d   = '0;
        op_d    = OP_NONE;
      end else begin
        case (state_q)
          S_ENTRY_A, S_ENTRY_B: begin
            if (w_is_digit) begin
              // Leading zeros do not consume a digit slot
              if ((count_q < CW'(MAX_DIGITS)) && !((key_code == 4'd0) && (acc_q == '0))) begin
                acc_d   = acc_q * WIDTH'(10) + w_digit;
                count_d = count_q + CW'(1);
              end
            end else if (key_code == KEY_BSP) begin
              if (count_q != '0) begin
                acc_d   = acc_q / WIDTH'(10);
                count_d = count_q - CW'(1);
              end
            end else if (state_q == S_ENTRY_A) begin
              if (w_is_op) begin
                opa_d   = w_acc_s;
                op_d    = w_key_op;
                state_d = S_OP_WAIT;
              end
            end else if (w_is_op || (key_code == KEY_EQ)) begin
              if (w_ovf) begin
                state_d = S_ERROR;
              end else if (key_code == KEY_EQ) begin
                opa_d   = w_res;
                op_d    = OP_NONE;
                state_d = S_RESULT;
                rv_d    = 1'b1;
              end else begin
                opa_d   = w_res;
                op_d    = w_key_op;
                state_d = S_OP_WAIT;
              end
            end
          end
          S_OP_WAIT: begin
            if (w_is_op) begin
              op_d = w_key_op;
            end else if (w_is_digit) begin
              acc_d   = w_digit;
              count_d = (key_code != 4'd0) ? CW'(1) : CW'(0);
              state_d = S_ENTRY_B;
            end
          end
          S_RESULT: begin
            if (w_is_digit) begin
              acc_d   = w_digit;
              count_d = (key_code != 4'd0) ? CW'(1) : CW'(0);
              opa_d   = '0;
              state_d = S_ENTRY_A;
            end else if (w_is_op) begin
              op_d    = w_key_op;
              state_d = S_OP_WAIT;
            end
          end
          default: begin
            // ERROR (and any illegal encoding) only leaves on C
          end
        endcase
      end
    end
  end

  // Display values derived from the next state so outputs are registered
  always_comb begin
    disp_mag_d   = '0;
    disp_neg_d   = 1'b0;
    op_pending_d = op_d;
    err_d        = 1'b0;
    case (state_d)
      S_ENTRY_A, S_ENTRY_B: begin
        disp_mag_d = acc_d;
      end
      S_OP_WAIT, S_RESULT: begin
        disp_mag_d = WIDTH'(opa_d[SW-1] ? -opa_d : opa_d);
        disp_neg_d = opa_d[SW-1];
      end
      default: begin
        op_pending_d = OP_NONE;
        err_d        = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_ENTRY_A;
      acc_q        <= '0;
      count_q      <= '0;
      opa_q        <= '0;
      op_q         <= OP_NONE;
      kv_q         <= 1'b0;
      disp_mag     <= '0;
      disp_neg     <= 1'b0;
      op_pending   <= OP_NONE;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      opa_q        <= opa_d;
      op_q         <= op_d;
      kv_q         <= key_valid;
      disp_mag     <= disp_mag_d;
      disp_neg     <= disp_neg_d;
      op_pending   <= op_pending_d;
      result_valid <= rv_d;
      err          <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_calc_entry.sv
// ============================================================================
// Module   : tb_calc_entry
// Purpose  : Self-checking bench for calc_entry: integer reference model
//            checked every cycle plus literal expectations per scenario.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_calc_entry;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [13:0] disp_mag;
  logic        disp_neg;
  logic [1:0]  op_pending;
  logic        result_valid;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int rv_seen  = 0;

  // Reference model state (plain integers, spec-level)
  int m_st   = 0;   // 0 ENTRY_A, 1 OP_WAIT, 2 ENTRY_B, 3 RESULT, 4 ERROR
  int m_acc  = 0;
  int m_cnt  = 0;
  int m_a    = 0;
  int m_op   = 0;   // 0 none, 1 add, 2 sub
  int m_rv   = 0;
  int m_prev = 0;

  calc_entry #(.MAX_DIGITS(4), .WIDTH(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .disp_mag     (disp_mag),
    .disp_neg     (disp_neg),
    .op_pending   (op_pending),
    .result_valid (result_valid),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_acc = 0; m_cnt = 0; m_a = 0; m_op = 0; m_rv = 0; m_prev = 0;
  endtask

  task automatic model_key(input int k);
    int r;
    if (k == 12) begin
      m_st = 0; m_acc = 0; m_cnt = 0; m_a = 0; m_op = 0;
      return;
    end
    case (m_st)
      0, 2: begin
        if (k <= 9) begin
          if (m_cnt < 4 && !(k == 0 && m_acc == 0)) begin
            m_acc = m_acc * 10 + k;
            m_cnt++;
          end
        end else if (k == 13) begin
          if (m_cnt > 0) begin
            m_acc = m_acc / 10;
            m_cnt--;
          end
        end else if (m_st == 0 && (k == 10 || k == 11)) begin
          m_a = m_acc; m_op = k - 9; m_st = 1;
        end else if (m_st == 2 && (k == 10 || k == 11 || k == 14)) begin
          r = (m_op == 1) ? m_a + m_acc : m_a - m_acc;
          if (r > 9999 || r < -9999) m_st = 4;
          else if (k == 14) begin
            m_a = r; m_op = 0; m_st = 3; m_rv = 1;
          end else begin
            m_a = r; m_op = k - 9; m_st = 1;
          end
        end
      end
      1: begin
        if (k == 10 || k == 11) m_op = k - 9;
        else if (k <= 9) begin
          m_acc = k; m_cnt = (k != 0) ? 1 : 0; m_st = 2;
        end
      end
      3: begin
        if (k <= 9) begin
          m_acc = k; m_cnt = (k != 0) ? 1 : 0; m_a = 0; m_st = 0;
        end else if (k == 10 || k == 11) begin
          m_op = k - 9; m_st = 1;
        end
      end
      default: ;
    endcase
  endtask

  // Model stepping on the same edges the DUT reacts to
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        m_rv = 0;
        if (key_valid && m_prev == 0) model_key(int'(key_code));
        m_prev = key_valid ? 1 : 0;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  initial begin
    int e_mag, e_neg, e_op, e_err;
    forever begin
      @(negedge clk);
      if (m_st == 4) begin
        e_mag = 0; e_neg = 0; e_op = 0; e_err = 1;
      end else if (m_st == 0 || m_st == 2) begin
        e_mag = m_acc; e_neg = 0; e_op = m_op; e_err = 0;
      end else begin
        e_mag = (m_a < 0) ? -m_a : m_a; e_neg = (m_a < 0) ? 1 : 0; e_op = m_op; e_err = 0;
      end
      chk("cyc_disp_mag", int'(disp_mag), e_mag);
      chk("cyc_disp_neg", int'(disp_neg), e_neg);
      chk("cyc_op_pending", int'(op_pending), e_op);
      chk("cyc_err", int'(err), e_err);
      chk("cyc_result_valid", int'(result_valid), m_rv);
      if (result_valid) rv_seen++;
    end
  end

  task automatic press(input int code);
    @(negedge clk);
    key_code  = 4'(code);
    key_valid = 1'b1;
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int rv0;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_mag", int'(disp_mag), 0);
    chk("reset_err", int'(err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Digit entry saturates at four digits; reserved key ignored
    press(1); press(2); press(15); press(3); press(4);
    chk("four_digits", int'(disp_mag), 1234);
    press(5);
    chk("fifth_ignored", int'(disp_mag), 1234);

    // Leading zeros and backspace past empty
    press(12);
    press(0); chk("lead_zero1", int'(disp_mag), 0);
    press(0); press(7); chk("after_7", int'(disp_mag), 7);
    press(13); chk("bsp1", int'(disp_mag), 0);
    press(13); chk("bsp_empty", int'(disp_mag), 0);
    press(3); chk("after_bsp_digit", int'(disp_mag), 3);

    // 25 + 17 = 42
    press(12);
    rv0 = rv_seen;
    press(2); press(5); press(10);
    chk("opw_op", int'(op_pending), 1);
    chk("opw_mag", int'(disp_mag), 25);
    press(1); press(7); press(14);
    chk("add_mag", int'(disp_mag), 42);
    chk("add_neg", int'(disp_neg), 0);
    chk("add_op", int'(op_pending), 0);
    chk("add_rv_count", rv_seen - rv0, 1);

    // 5 - 9 = -4, then chained +10 = 6
    press(12);
    press(5); press(11); press(9); press(14);
    chk("sub_mag", int'(disp_mag), 4);
    chk("sub_neg", int'(disp_neg), 1);
    press(10); press(1); press(0); press(14);
    chk("chain_mag", int'(disp_mag), 6);
    chk("chain_neg", int'(disp_neg), 0);

    // Chaining with operator replacement: 8 A B 3 A -> 5 shown, then 2 # -> 7
    press(12);
    press(8); press(10); press(11); press(3); press(10);
    chk("chain_opw_mag", int'(disp_mag), 5);
    press(2); press(14);
    chk("chain2_mag", int'(disp_mag), 7);

    // Overflow: 9999 + 1
    press(12);
    rv0 = rv_seen;
    press(9); press(9); press(9); press(9); press(10); press(1); press(14);
    chk("ovf_err", int'(err), 1);
    chk("ovf_mag", int'(disp_mag), 0);
    chk("ovf_rv_count", rv_seen - rv0, 0);
    press(3);
    chk("err_sticky", int'(err), 1);
    press(12);
    chk("clear_err", int'(err), 0);
    chk("clear_mag", int'(disp_mag), 0);

    // Long held key acts once
    @(negedge clk);
    key_code  = 4'd8;
    key_valid = 1'b1;
    repeat (50) @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_once", int'(disp_mag), 8);
    press(3);
    chk("held_then_3", int'(disp_mag), 83);

    // Asynchronous reset mid-entry
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mag", int'(disp_mag), 0);
    chk("async_rst_rv", int'(result_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    press(6);
    chk("post_rst_digit", int'(disp_mag), 6);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
